i2c_cmd_arbiter: RTL and testbench

Shares the single I2C command parser between two command sources: requester 0 (host/JTAG command path) and requester 1 (autonomous monitor/readback). The block sits upstream of the parser. It holds the granted command's device, address, byte count and direction stable, raises the parser's start/not-empty controls, and waits for the parser's clear-start acknowledge. It then releases the parser and hands it to the other requester on a round-robin basis.

---
 rtl/i2c_cmd_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
//   Shares one I2C command parser between requester 0 (host/JTAG path) and
//   requester 1 (autonomous monitor). The granted command is latched, offered
//   to the parser with start/not-empty, held until the parser's clear-start
//   acknowledge, then released. Ownership alternates round-robin.
//
//   Optional feature macro: I2C_ARB_TIMEOUT_EN
//     defined   : START aborts after TMO_CYCLES cycles without parser_clr_i,
//                 pulsing tmo_err_o together with the requester's done.
//     undefined : no counter, tmo_err_o is constant 0.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req{0,1}_i                   level requests, held until done
//   dev/addr/nb/rd{0,1}_i        per-requester command fields
//   parser_clr_i, parser_idle_i  parser clear-start pulse, parser idle level
//   i2c_start_o, cmd_mt_o        start level / command-empty flag to parser
//   cmd_dev/addr/nb/rd_o         latched command fields
//   gnt{0,1}_o, done{0,1}_o      grant level, one-cycle completion pulse
//   tmo_err_o                    one-cycle abort pulse
module i2c_cmd_arbiter #(
  parameter int unsigned          TMO_W      = 16,
  parameter logic [TMO_W-1:0]     TMO_CYCLES = '1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [7:0]  dev0_i,
  input  logic [7:0]  dev1_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] addr1_i,
  input  logic [3:0]  nb0_i,
  input  logic [3:0]  nb1_i,
  input  logic        rd0_i,
  input  logic        rd1_i,
  input  logic        parser_clr_i,
  input  logic        parser_idle_i,
  output logic        i2c_start_o,
  output logic        cmd_mt_o,
  output logic [7:0]  cmd_dev_o,
  output logic [15:0] cmd_addr_o,
  output logic [3:0]  cmd_nb_o,
  output logic        cmd_rd_o,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic        tmo_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;      // 1 = requester 1 preferred on a tie
  logic        rel_q, rel_d;      // set after the first RELEASE cycle
  logic        start_q, start_d;
  logic        mt_q, mt_d;
  logic [7:0]  dev_q, dev_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  nb_q, nb_d;
  logic        rd_q, rd_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        tmo_q, tmo_d;
  logic        pick1;
  logic        abort;

  // Requester 1 wins when it is alone or when both ask and it is preferred.
  assign pick1 = req1_i & (~req0_i | ptr_q);

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [TMO_W:0]   cnt_inc;

  // cnt_q counts START cycles already spent; this cycle makes cnt_q+1.
  assign cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
  assign abort   = (state_q == S_START) && (cnt_inc >= {1'b0, TMO_CYCLES});
  assign cnt_d   = (state_q == S_LOAD)  ? '0 :
                   (state_q != S_START) ? cnt_q :
                   (&cnt_q)             ? cnt_q : cnt_inc[TMO_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign abort      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rel_d   = rel_q;
    start_d = start_q;
    mt_d    = mt_q;
    dev_d   = dev_q;
    addr_d  = addr_q;
    nb_d    = nb_q;
    rd_d    = rd_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((req0_i | req1_i) && parser_idle_i) begin
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          dev_d   = pick1 ? dev1_i  : dev0_i;
          addr_d  = pick1 ? addr1_i : addr0_i;
          nb_d    = pick1 ? nb1_i   : nb0_i;
          rd_d    = pick1 ? rd1_i   : rd0_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        start_d = 1'b1;
        mt_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        // A real acknowledge takes priority over a same-cycle timeout.
        if (parser_clr_i || abort) begin
          tmo_d   = ~parser_clr_i;
          start_d = 1'b0;
          mt_d    = 1'b1;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          rel_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Two cycles minimum so a request dropped after done is not re-granted.
        if (!rel_q) begin
          rel_d = 1'b1;
        end else if (parser_idle_i) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          ptr_d   = gnt0_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      rel_q   <= 1'b0;
      start_q <= 1'b0;
      mt_q    <= 1'b1;
      dev_q   <= '0;
      addr_q  <= '0;
      nb_q    <= '0;
      rd_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rel_q   <= rel_d;
      start_q <= start_d;
      mt_q    <= mt_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      rd_q    <= rd_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      tmo_q   <= tmo_d;
    end
  end

  assign i2c_start_o = start_q;
  assign cmd_mt_o    = mt_q;
  assign cmd_dev_o   = dev_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_nb_o    = nb_q;
  assign cmd_rd_o    = rd_q;
  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign tmo_err_o   = tmo_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter
//   Directed and randomized transactions against a transaction-level model:
//   winner from request levels and a round-robin preference, command fields
//   captured at grant, fixed grant/start/done latencies, and a RELEASE length
//   of max(2, parser-busy cycles + 1).
module tb_i2c_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  dev0, dev1;
  logic [15:0] addr0, addr1;
  logic [3:0]  nb0, nb1;
  logic        rd0, rd1;
  logic        parser_clr, parser_idle;
  logic        i2c_start, cmd_mt;
  logic [7:0]  cmd_dev;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_nb;
  logic        cmd_rd;
  logic        gnt0, gnt1, done0, done1, tmo_err;

  int n_cmp = 0;
  int n_err = 0;
  bit mptr  = 1'b0;   // model: 1 = requester 1 preferred

  i2c_cmd_arbiter #(.TMO_W(16), .TMO_CYCLES(16'd16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .dev0_i(dev0), .dev1_i(dev1),
    .addr0_i(addr0), .addr1_i(addr1),
    .nb0_i(nb0), .nb1_i(nb1),
    .rd0_i(rd0), .rd1_i(rd1),
    .parser_clr_i(parser_clr), .parser_idle_i(parser_idle),
    .i2c_start_o(i2c_start), .cmd_mt_o(cmd_mt),
    .cmd_dev_o(cmd_dev), .cmd_addr_o(cmd_addr),
    .cmd_nb_o(cmd_nb), .cmd_rd_o(cmd_rd),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .done0_o(done0), .done1_o(done1),
    .tmo_err_o(tmo_err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] IDLE_CTL = 7'b0100000;

  // {start, mt, gnt1, gnt0, done1, done0, tmo}
  function automatic logic [6:0] ctl();
    return {i2c_start, cmd_mt, gnt1, gnt0, done1, done0, tmo_err};
  endfunction

  function automatic logic [28:0] cmd();
    return {cmd_dev, cmd_addr, cmd_nb, cmd_rd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    dev0 = 8'($urandom);  dev1 = 8'($urandom);
    addr0 = 16'($urandom); addr1 = 16'($urandom);
    nb0 = 4'($urandom);   nb1 = 4'($urandom);
    rd0 = 1'($urandom);   rd1 = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check("reset_ctl", 32'(ctl()), 32'(IDLE_CTL));
    check("reset_cmd", 32'(cmd()), 32'd0);
    rst = 1'b0;
    mptr = 1'b0;
  endtask

  // One full grant/start/done/release cycle. Caller leaves the DUT in IDLE
  // with requests set and parser_idle=1; the DUT is back in IDLE on return.
  task automatic txn(input int clr_lat, input int idle_lat, input bit drop);
    int          w;
    int          rel_len;
    logic [1:0]  g;
    logic [28:0] ef;
    w  = (req0 && req1) ? int'(mptr) : (req1 ? 1 : 0);
    g  = (w == 1) ? 2'b10 : 2'b01;
    ef = (w == 1) ? {dev1, addr1, nb1, rd1} : {dev0, addr0, nb0, rd0};
    step();
    check("grant", 32'(ctl()), 32'({2'b01, g, 3'b000}));
    check("cmd_load", 32'(cmd()), 32'(ef));
    // Field changes after grant and a stray clear during LOAD are ignored.
    rand_fields();
    dev0 = 8'h55;
    parser_clr = 1'($urandom_range(0, 1));
    step();
    parser_clr = 1'b0;
    check("start", 32'(ctl()), 32'({2'b10, g, 3'b000}));
    repeat (clr_lat) begin
      step();
      check("start_hold", 32'(ctl()), 32'({2'b10, g, 3'b000}));
      check("cmd_frozen", 32'(cmd()), 32'(ef));
    end
    parser_clr  = 1'b1;
    parser_idle = (idle_lat == 0);
    step();
    parser_clr = 1'b0;
    check("done", 32'(ctl()), 32'({2'b01, g, g, 1'b0}));
    if (drop) begin
      if (w == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    mptr    = (w == 0);
    rel_len = (idle_lat + 1 > 2) ? idle_lat + 1 : 2;
    for (int n = 0; n < rel_len; n++) begin
      if (n >= idle_lat) parser_idle = 1'b1;
      step();
      check("release", 32'(ctl()),
            (n + 1 < rel_len) ? 32'({2'b01, g, 3'b000}) : 32'(IDLE_CTL));
      check("cmd_rel", 32'(cmd()), 32'(ef));
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    parser_clr = 1'b0; parser_idle = 1'b1;
    dev0 = '0; dev1 = '0; addr0 = '0; addr1 = '0;
    nb0 = '0; nb1 = '0; rd0 = 1'b0; rd1 = 1'b0;
    step();
    do_reset();

    // Basic write command from requester 0.
    dev0 = 8'hA0; addr0 = 16'h0010; nb0 = 4'd4; rd0 = 1'b0; req0 = 1'b1;
    txn(3, 0, 1'b1);

    // Both held continuously from reset: strict alternation.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      txn(int'($urandom_range(0, 3)), 0, 1'b0);
    end

    // Parser busy blocks the grant.
    req0 = 1'b0; req1 = 1'b1; parser_idle = 1'b0;
    repeat (3) begin
      step();
      check("busy_no_grant", 32'(ctl()), 32'(IDLE_CTL));
    end
    parser_idle = 1'b1;
    rand_fields();
    txn(1, 2, 1'b1);

    // Random request mixes, acknowledge latencies and parser-busy tails.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      req0 = r[0]; req1 = r[1];
      rand_fields();
      txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1);
    end

    // No acknowledge: abort with timeout, or wait forever without it.
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1;
    step();
    check("tmo_grant", 32'(ctl()), 32'({2'b01, 2'b01, 3'b000}));
    step();
    check("tmo_start", 32'(ctl()), 32'({2'b10, 2'b01, 3'b000}));
`ifdef I2C_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!tmo_err && n < 100) begin
        step();
        n++;
      end
      check("tmo_latency", 32'(n), 32'd16);
      check("tmo_done", 32'(ctl()), 32'({2'b01, 2'b01, 2'b01, 1'b1}));
      req0 = 1'b0;
      step();
      check("tmo_pulse", 32'(ctl()), 32'({2'b01, 2'b01, 3'b000}));
      step();
      check("tmo_release", 32'(ctl()), 32'(IDLE_CTL));
    end
`else
    repeat (1000) step();
    check("no_tmo", 32'(ctl()), 32'({2'b10, 2'b01, 3'b000}));
`endif

    // Reset in the middle of START.
    do_reset();
    req0 = 1'b1; req1 = 1'b0;
    dev0 = 8'hA0;
    step();
    step();
    check("pre_rst_start", 32'(ctl()), 32'({2'b10, 2'b01, 3'b000}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ctl", 32'(ctl()), 32'(IDLE_CTL));
    check("rst_mid_cmd", 32'(cmd()), 32'd0);
    mptr = 1'b0;
    req0 = 1'b0; req1 = 1'b1;
    rand_fields();
    txn(2, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
